// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: fetch/data arbiter for one single-port memory, data-first
// with a bounded run of data grants while a fetch waits.   Revision 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam logic [3:0] c_max_consec = 4'(MAX_CONSEC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [3:0]  consec_q, consec_d;
  logic        fetch_starved;

  // A waiting fetch overrides the data port once the data run hits its limit.
  assign fetch_starved = if_req && (consec_q == c_max_consec);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    consec_d    = consec_q;
    case (state_q)
      IDLE: begin
        if (d_req && !fetch_starved) begin
          state_d     = D_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
          if (consec_q < c_max_consec) consec_d = consec_q + 4'd1;
        end else if (if_req) begin
          state_d     = IF_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'd0;
          mem_wstrb_d = 4'd0;
          consec_d    = 4'd0;
        end
      end
      IF_WAIT: begin
        if (mem_ack) begin
          state_d    = DONE;
          mem_req_d  = 1'b0;
          if_ready_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      D_WAIT: begin
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          d_ready_d = 1'b1;
          if (!mem_we_q) d_rdata_d = mem_rdata;
        end
      end
      // DONE never grants, so a requester can drop req after its ready pulse.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      consec_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      consec_q    <= consec_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_CONSEC, default 4: maximum consecutive data-port grants while an instruction-fetch request waits; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 if_req  input  1  fetch request; held high with stable if_addr until if_ready.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_ready  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-007 if_rdata  output  32  fetched instruction word.
REQ-008 d_req  input  1  data request; held high with stable d_we/d_addr/d_wdata/d_wstrb until d_ready.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  32  data address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_wstrb  input  4  store byte enables.
REQ-013 d_ready  output  1  one-cycle pulse: data access complete.
REQ-014 d_rdata  output  32  load data.
REQ-015 mem_req  output  1  request to the shared single-port memory.
REQ-016 mem_we, mem_addr, mem_wdata, mem_wstrb  output  1/32/32/4  memory command fields.
REQ-017 mem_ack  input  1  memory completion, one cycle; mem_rdata valid in the same cycle.
REQ-018 mem_rdata  input  32  memory read data.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, IF_WAIT, D_WAIT, DONE.
REQ-021 In IDLE with no request: remain IDLE, mem_req = 0.
REQ-022 In IDLE with a request, grant selection SHALL be: data port wins unless if_req = 1 and consec_cnt == MAX_CONSEC, in which case fetch wins; a lone request always wins.
REQ-023 Grant at edge N SHALL register mem_req = 1 and the granted port's command fields, visible in cycle N+1 (one-cycle request latency); a fetch grant SHALL drive mem_we = 0, mem_wstrb = 0, mem_wdata = 0.
REQ-024 In IF_WAIT/D_WAIT, mem_req and all command fields SHALL stay constant until mem_ack is sampled high.
REQ-025 On mem_ack at edge M: mem_req <= 0, state <= DONE, granted port's ready <= 1 for exactly one cycle (cycle M+1).
REQ-026 Loads and fetches SHALL capture mem_rdata into d_rdata/if_rdata at edge M; stores SHALL leave d_rdata unchanged.
REQ-027 DONE SHALL last exactly one cycle and then return to IDLE; no new grant is made in DONE, so requesters may drop req after seeing ready (minimum 3 cycles per transaction at zero memory wait).
REQ-028 consec_cnt (4 bits): +1 on each data grant, saturating at MAX_CONSEC; cleared to 0 on each fetch grant.
REQ-029 mem_ack sampled in IDLE or DONE SHALL be ignored with no output change.
REQ-030 Requests arriving or changing during IF_WAIT/D_WAIT/DONE SHALL not affect the in-flight transaction; they are evaluated in the next IDLE cycle.
REQ-031 if_ready and d_ready SHALL never be high in the same cycle.

Reset
REQ-032 rst = 1 SHALL immediately force state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, if_ready 0, d_ready 0, if_rdata 0, d_rdata 0, consec_cnt 0, busy 0.
REQ-033 Reset during IF_WAIT/D_WAIT SHALL abandon the transaction with no ready pulse; a mem_ack arriving after reset release in IDLE is ignored per REQ-029.

Verification
REQ-034 Lone fetch: if_req, if_addr = 0x00000010, memory acks 2 cycles after mem_req with 0x00000013 -> mem_addr 0x10, mem_we 0, one if_ready pulse, if_rdata = 0x00000013.
REQ-035 Store: d_req, d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, d_wstrb = 0xF -> identical mem fields, one d_ready pulse, d_rdata unchanged.
REQ-036 Simultaneous if_req and d_req in IDLE, consec_cnt = 0 -> data granted first, fetch granted in the next IDLE cycle.
REQ-037 Starvation: if_req held with d_req held continuously, MAX_CONSEC = 4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-038 Reset asserted in D_WAIT, released, then a stray mem_ack -> no d_ready pulse, state IDLE, all outputs 0.
REQ-039 Zero-wait memory (mem_ack in the first mem_req cycle) -> ready pulse in the next cycle, then DONE then IDLE, 3-cycle transaction period.
